addsub_digit_sequencer: RTL and testbench
=========================================

# addsub_digit_sequencer

Multi-cycle add/subtract sequencer that sits directly upstream of the 3-bit adder (`threebitadder`) and consumes its outputs. It accepts wide operands over a valid/ready handshake and feeds them to the adder one 3-bit digit per cycle, least significant digit first. Because the adder has no carry-in, the sequencer applies the inter-digit carry and the subtract inversion itself. It returns the registered wide result, carry and signed-overflow flags over a second valid/ready handshake.

## Interface
- `DIGITS`, default 4: number of 3-bit digits. Operand width W = 3*DIGITS; the default gives 12 bits. Legal range is ≥1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand request.
- `in_ready`  out  1: sequencer can accept an operand request.
- `in_a`  in  W: operand A.
- `in_b`  in  W: operand B.
- `in_sub`  in  1: 0 computes A+B; 1 computes A−B.
- `add_a`  out  3: digit driven to the adder's A port.
- `add_b`  out  3: effective digit driven to the adder's B port.
- `add_y`  in  3: adder sum Y, combinational from `add_a`/`add_b`.
- `add_co`  in  1: adder carry Co.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  W: result, modulo 2^W.
- `out_carry`  out  1: unsigned carry out. For subtract, 1 = no borrow (A ≥ B unsigned).
- `out_ovf`  out  1: two's-complement signed overflow.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch A, B and `in_sub`; clear digit index k to 0; set running carry c = `in_sub`; go to RUN.
- **RUN**
  - `add_a` = A[3k+2:3k].
  - `add_b` = B[3k+2:3k] XOR {3{sub}}.
- **Digit combine (per RUN cycle)**
  - d = (`add_y` + c) mod 8.
  - cn = `add_co` OR (`add_y`==3'b111 AND c).
  - `add_co` and the `add_y`==7-with-carry case are mutually exclusive, since A+B ≥ 8 implies Y ≤ 6.
  - d is written into result digit k; c ← cn; k ← k+1.
  - After digit DIGITS−1, go to DONE.
- **DONE**
  - `out_valid`=1.
  - `out_sum` = assembled digits.
  - `out_carry` = final c.
  - `out_ovf` = (A[W−1] == Beff[W−1]) AND (`out_sum`[W−1] != A[W−1]), where Beff = B XOR {W{sub}}.
  - On `out_ready`, go to IDLE.
- `in_ready` = (state==IDLE) AND NOT `rst`. `in_valid` is ignored outside IDLE.
- `add_a`/`add_b` = 3'b000 outside RUN.
- `out_sum`, `out_carry` and `out_ovf` hold stable through DONE. They keep their last values in IDLE but are meaningful only while `out_valid`=1.
- **Reset (including mid-RUN or mid-DONE):** state IDLE, k=0, c=0, latched operands 0, `out_valid`=0, `out_sum`=0, `out_carry`=0, `out_ovf`=0. Any in-flight operation is discarded without output.

## Timing
- **Acceptance:** at the edge E0 where `in_valid` AND `in_ready`.
- **Digit capture:** digit k is computed combinationally in the cycle after edge E0+k and captured at edge E0+k+1.
- **Output:** `out_valid` rises after edge E0+DIGITS. Latency = DIGITS cycles (4 at default).
- **Consumer handshake:** the edge with `out_valid` AND `out_ready` drops `out_valid` and returns to IDLE. `in_ready` is 1 in the following cycle.
- **Back-pressure:** with `out_ready` held low, DONE persists indefinitely and `in_ready` stays 0.
- **Throughput:** with no back-pressure, minimum spacing between acceptances is DIGITS+2 cycles.
- **Adder path:** `add_y`/`add_co` are assumed settled within the same cycle as `add_a`/`add_b`; there is no registered stage inside the adder path.
- **Simultaneous reset:** `rst` high on an edge overrides every handshake on that edge.

## Test plan
1. **Basic add.** Reset, then add 12'h001 + 12'h000.
   - `out_sum`=12'h001, carry 0, ovf 0.
   - `out_valid` first high exactly 4 cycles after the acceptance edge.
2. **Carry chain through a Y=7 digit.** Add 12'o0037 + 12'o0041 (31+33).
   - `out_sum`=12'o0100, carry 0, ovf 0.
   - Digit 1 exercises `add_y`=7 with c=1.
3. **Carry and overflow.**
   - Add 12'hFFF + 12'h001 → 12'h000, carry 1, ovf 0.
   - Add 12'h7FF + 12'h001 → 12'h800, carry 0, ovf 1.
4. **Subtract.**
   - 12'h005 − 12'h007 → 12'hFFE, carry 0, ovf 0.
   - 12'h800 − 12'h001 → 12'h7FF, carry 1, ovf 1.
   - `add_b` digits are inverted during RUN.
5. **Back-pressure.** Hold `out_ready`=0 for 6 cycles in DONE while toggling `in_valid` and inputs.
   - Outputs stay constant and `in_ready`=0.
   - Raise `out_ready`: `out_valid` drops after one edge; `in_ready`=1 the next cycle.
6. **Reset mid-operation.** Assert `rst` for one cycle at RUN digit 2.
   - All outputs are 0 and `in_ready`=1 the cycle after reset deasserts.
   - A following 12'h123 + 12'h456 yields 12'h579 with carry 0.

Source files
------------

// File: rtl/addsub_digit_sequencer.sv
// addsub_digit_sequencer
//
// Multi-cycle add/subtract sequencer wrapped around an external 3-bit adder
// that has no carry-in. Wide operands are accepted over a valid/ready
// handshake. They are fed to the adder one 3-bit digit per cycle, least
// significant digit first. The sequencer supplies the inter-digit carry and the
// subtract inversion itself. The registered result is returned over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready operand handshake; in_a, in_b (W bits), in_sub (1 = A-B)
//   add_a, add_b      3-bit digits driven to the adder (zero outside RUN)
//   add_y, add_co     adder sum and carry, combinational from add_a/add_b
//   out_valid/ready   result handshake; out_sum (W bits), out_carry, out_ovf
module addsub_digit_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*DIGITS-1:0]   in_a,
  input  logic [3*DIGITS-1:0]   in_b,
  input  logic                  in_sub,
  output logic [2:0]            add_a,
  output logic [2:0]            add_b,
  input  logic [2:0]            add_y,
  input  logic                  add_co,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*DIGITS-1:0]   out_sum,
  output logic                  out_carry,
  output logic                  out_ovf
);

  localparam int DIGIT_W = 3;
  localparam int W       = DIGIT_W * DIGITS;
  localparam int KW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Adds the running carry onto the adder's digit sum. add_co and the
  // "Y==7 with carry" case never occur together, so OR-ing them is exact.
  function automatic logic [3:0] digit_combine(input logic [2:0] y,
                                               input logic       co,
                                               input logic       c);
    logic [2:0] d;
    logic       cn;
    d  = y + {2'b00, c};
    cn = co | ((y == 3'b111) & c);
    return {cn, d};
  endfunction

  state_t        state_r;
  state_t        next_state_s;
  logic [KW-1:0] k_r;
  logic          c_r;
  // Operands are shifted right one digit per RUN cycle, so digit 0 is always
  // at the bottom. b_r holds the already-inverted effective operand.
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          a_msb_r;
  logic          beff_msb_r;
  logic [W-1:0]  sum_r;
  logic          carry_r;
  logic          ovf_r;

  logic [3:0]    combine_s;
  logic [2:0]    d_s;
  logic          cn_s;
  logic [W-1:0]  sum_next_s;

  // Per-digit carry combine and result shift-in (new digit enters at the top).
  always_comb begin
    combine_s  = digit_combine(add_y, add_co, c_r);
    d_s        = combine_s[2:0];
    cn_s       = combine_s[3];
    sum_next_s = (sum_r >> DIGIT_W) | (W'(d_s) << (W - DIGIT_W));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (k_r == K_LAST) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM-decoded outputs: handshake flags and adder digit drive.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 3'b000;
    add_b     = 3'b000;
    case (state_r)
      IDLE: begin
        in_ready = ~rst;
      end
      RUN: begin
        add_a = a_r[2:0];
        add_b = b_r[2:0];
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Operand latch, digit stepping and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r        <= '0;
      c_r        <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      a_msb_r    <= 1'b0;
      beff_msb_r <= 1'b0;
      sum_r      <= '0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= in_a;
            b_r        <= in_b ^ {W{in_sub}};
            a_msb_r    <= in_a[W-1];
            beff_msb_r <= in_b[W-1] ^ in_sub;
            k_r        <= '0;
            // Subtract is A + ~B + 1: the +1 enters as the initial carry.
            c_r        <= in_sub;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT_W;
          b_r   <= b_r >> DIGIT_W;
          sum_r <= sum_next_s;
          c_r   <= cn_s;
          k_r   <= k_r + KW'(1);
          if (k_r == K_LAST) begin
            carry_r <= cn_s;
            // d_s[2] is the result MSB, since the last digit is being written.
            ovf_r   <= (a_msb_r == beff_msb_r) & (d_s[2] != a_msb_r);
          end
        end
        default: begin
          k_r <= k_r;
        end
      endcase
    end
  end

  assign out_sum   = sum_r;
  assign out_carry = carry_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_addsub_digit_sequencer.sv
module tb_addsub_digit_sequencer;

  localparam int DIGITS = 4;
  localparam int W      = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_sub;
  logic [2:0]    add_a;
  logic [2:0]    add_b;
  logic [2:0]    add_y;
  logic          add_co;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic          out_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural 3-bit adder (no carry-in).
  assign {add_co, add_y} = {1'b0, add_a} + {1'b0, add_b};

  addsub_digit_sequencer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_y(add_y), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one operation; hold = cycles to stall in DONE with out_ready low.
  task automatic run_vec(input vec_t v, input int hold);
    int           lat;
    logic [W-1:0] seen_a;
    logic [W-1:0] seen_b;
    logic [W-1:0] held_sum;
    lat    = 0;
    seen_a = '0;
    seen_b = '0;
    @(negedge clk);
    check({v.name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_a      = v.a;
    in_b      = v.b;
    in_sub    = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      if (lat < DIGITS) begin
        seen_a[3*lat +: 3] = add_a;
        seen_b[3*lat +: 3] = add_b;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'd4);
    check({v.name, " out_sum"}, 32'(out_sum), 32'(v.sum));
    check({v.name, " out_carry"}, 32'(out_carry), 32'(v.carry));
    check({v.name, " out_ovf"}, 32'(out_ovf), 32'(v.ovf));
    check({v.name, " add_a digits"}, 32'(seen_a), 32'(v.a));
    check({v.name, " add_b digits"}, 32'(seen_b), 32'(v.b ^ {W{v.sub}}));
    held_sum = v.sum;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_a     = 12'(i * 12'h155);
      in_b     = 12'(i * 12'h2a3);
      in_sub   = ~in_sub;
      @(posedge clk);
      #1;
      check({v.name, " stall out_valid"}, 32'(out_valid), 32'd1);
      check({v.name, " stall out_sum"}, 32'(out_sum), 32'(held_sum));
      check({v.name, " stall flags"}, 32'({out_carry, out_ovf}), 32'({v.carry, v.ovf}));
      check({v.name, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({v.name, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({v.name, " in_ready after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{"add_basic",  12'h001,  12'h000,  1'b0, 12'h001,  1'b0, 1'b0};
    vecs[1] = '{"add_y7",     12'o0037, 12'o0041, 1'b0, 12'o0100, 1'b0, 1'b0};
    vecs[2] = '{"add_wrap",   12'hFFF,  12'h001,  1'b0, 12'h000,  1'b1, 1'b0};
    vecs[3] = '{"add_ovf",    12'h7FF,  12'h001,  1'b0, 12'h800,  1'b0, 1'b1};
    vecs[4] = '{"sub_borrow", 12'h005,  12'h007,  1'b1, 12'hFFE,  1'b0, 1'b0};
    vecs[5] = '{"sub_ovf",    12'h800,  12'h001,  1'b1, 12'h7FF,  1'b1, 1'b1};
    vecs[6] = '{"sub_equal",  12'h555,  12'h555,  1'b1, 12'h000,  1'b1, 1'b0};
    vecs[7] = '{"add_negneg", 12'h800,  12'h800,  1'b0, 12'h000,  1'b1, 1'b1};
    vecs[8] = '{"add_mixed",  12'h123,  12'h456,  1'b0, 12'h579,  1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready in reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset flags", 32'({out_carry, out_ovf}), 32'd0);
    check("reset add digits", 32'({add_a, add_b}), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], 0);
    end

    // Back-pressure: stall 6 cycles in DONE while inputs toggle.
    run_vec(vecs[5], 6);

    // Reset in the cycle where digit 2 is being computed.
    @(negedge clk);
    in_a     = 12'hFFF;
    in_b     = 12'h001;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun out_valid", 32'(out_valid), 32'd0);
    check("midrun out_sum", 32'(out_sum), 32'd0);
    check("midrun flags", 32'({out_carry, out_ovf}), 32'd0);
    check("midrun add digits", 32'({add_a, add_b}), 32'd0);
    check("midrun in_ready", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    check("midrun no output", 32'(lat), 32'd0);
    run_vec(vecs[8], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
